// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32 memory stage with req/ack data bus, stall generation and MEM/WB register.
// Define DMEM_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES without an ack.
module mem_access_stage #(
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [4:0]        RD_M,
  input  logic [DATA_W-1:0] PCPlus4M,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [DATA_W-1:0] ALU_ResultM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_m,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [4:0]        RD_W,
  output logic [DATA_W-1:0] PCPlus4W,
  output logic [DATA_W-1:0] ALU_ResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ResultW,
  output logic              mem_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nxt;
  logic mem_op, abort;
  assign mem_op = MemWriteM | ResultSrcM;
  assign dmem_addr = ALU_ResultM;
  assign dmem_wdata = WriteDataM;
  assign dmem_we = MemWriteM;
`ifdef DMEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt;
  logic err;
  // The IDLE request cycle counts toward the budget, so the abort lands on the (TIMEOUT_CYCLES-1)th stalled cycle's successor.
  assign abort = (state == WAIT) & ~dmem_ack & (cnt == CW'(TIMEOUT_CYCLES - 2));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (state == IDLE) ? '0 : cnt + 1'b1;
      err <= err | abort;
    end
  assign mem_err = err;
`else
  assign abort = 1'b0;
  assign mem_err = 1'b0;
`endif
  always_comb begin
    dmem_req = (state == WAIT) ? ~abort : mem_op;
    stall_m = mem_op & ~dmem_ack & ~abort;
    state_nxt = stall_m ? WAIT : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      RegWriteW <= 1'b0;
      ResultSrcW <= 1'b0;
      RD_W <= '0;
      PCPlus4W <= '0;
      ALU_ResultW <= '0;
      ReadDataW <= '0;
    end else if (stall_m) begin
      RegWriteW <= 1'b0;
      ResultSrcW <= 1'b0;
      RD_W <= '0;
    end else begin
      RegWriteW <= RegWriteM & ~abort;
      ResultSrcW <= ResultSrcM;
      RD_W <= RD_M;
      PCPlus4W <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW <= (ResultSrcM & ~abort) ? dmem_rdata : '0;
    end
  assign ResultW = ResultSrcW ? ReadDataW : ALU_ResultW;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scoreboard bench for mem_access_stage (default build, no timeout).
module tb_mem_access_stage;
  logic clk = 1'b0, rst = 1'b0;
  logic RegWriteM = 0, MemWriteM = 0, ResultSrcM = 0, dmem_ack = 0;
  logic [4:0] RD_M = '0;
  logic [31:0] PCPlus4M = '0, WriteDataM = '0, ALU_ResultM = '0, dmem_rdata = '0;
  logic dmem_req, dmem_we, stall_m, RegWriteW, ResultSrcW, mem_err;
  logic [4:0] RD_W;
  logic [31:0] dmem_addr, dmem_wdata, PCPlus4W, ALU_ResultW, ReadDataW, ResultW;

  mem_access_stage #(.DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_m(stall_m), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .RD_W(RD_W), .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW), .ResultW(ResultW), .mem_err(mem_err));

  always #5 clk = ~clk;

  typedef struct {
    logic rw;
    logic [4:0] rd;
    logic [31:0] pc, res, rdata;
    int cyc;
  } exp_t;
  exp_t q[$];
  int pass = 0, total = 0, cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // An instruction is visible in W when RD_W is nonzero; every issued instruction uses rd != 0.
  always @(negedge clk) if (rst) begin
    if (RD_W != 5'd0) begin
      if (q.size() == 0) chk("w_unexpected_rd", {59'd0, RD_W}, 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("w_regwrite", {63'd0, RegWriteW}, {63'd0, e.rw});
        chk("w_rd", {59'd0, RD_W}, {59'd0, e.rd});
        chk("w_pcplus4", {32'd0, PCPlus4W}, {32'd0, e.pc});
        chk("w_result", {32'd0, ResultW}, {32'd0, e.res});
        chk("w_readdata", {32'd0, ReadDataW}, {32'd0, e.rdata});
        chk("w_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else chk("bubble_regwrite", {63'd0, RegWriteW}, 64'd0);
  end

  task automatic clear_m();
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RD_M = '0;
    PCPlus4M = '0; WriteDataM = '0; ALU_ResultM = '0; dmem_ack = 0; dmem_rdata = 32'hDEAD_BEEF;
  endtask

  // ack_at: cycle (1-based) carrying dmem_ack; 0 means a non-memory instruction.
  task automatic issue(input logic rw, mw, rs, input logic [4:0] rd,
                       input logic [31:0] alu, wd, rdat, input int ack_at);
    int stalls = 0, reqs = 0, n;
    exp_t e;
    n = (ack_at > 0) ? ack_at : 1;
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    PCPlus4M = {25'd0, rd, 2'b00} + 32'd4; WriteDataM = wd; ALU_ResultM = alu;
    for (int c = 1; c <= n; c++) begin
      dmem_ack = (c == ack_at);
      dmem_rdata = (c == ack_at) ? rdat : 32'hDEAD_BEEF;
      #3;
      stalls += int'(stall_m);
      reqs += int'(dmem_req);
      if (c == 1 && ack_at > 0)
        chk("bus_we_addr_wdata", {dmem_we, dmem_addr, dmem_wdata[30:0]}, {mw, alu, wd[30:0]});
      if (c == n) begin
        e.rw = rw; e.rd = rd; e.pc = {25'd0, rd, 2'b00} + 32'd4;
        e.res = rs ? rdat : alu; e.rdata = rs ? rdat : 32'd0; e.cyc = cyc + 1;
        q.push_back(e);
      end
      @(posedge clk); #1;
    end
    clear_m();
    chk("stall_cycles", 64'(stalls), 64'((ack_at > 0) ? ack_at - 1 : 0));
    chk("req_cycles", 64'(reqs), 64'((ack_at > 0) ? ack_at : 0));
  endtask

  task automatic idle(input int n);
    clear_m();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    clear_m();
    #2;
    chk("rst_w_fields", {RegWriteW, ResultSrcW, RD_W, ResultW, PCPlus4W}, 64'd0);
    chk("rst_flags", {61'd0, mem_err, stall_m, dmem_req}, 64'd0);
    #10 rst = 1'b1;
    @(posedge clk); #1;
    issue(1, 0, 0, 5'd5, 32'h0000_0010, 32'h0, 32'h0, 0);
    issue(1, 0, 1, 5'd6, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 1);
    issue(0, 1, 0, 5'd7, 32'h0000_0200, 32'h1234_5678, 32'h0, 3);
    issue(1, 0, 1, 5'd8, 32'h0000_0104, 32'h0, 32'h0BAD_C0DE, 2);
    issue(1, 0, 0, 5'd9, 32'h0000_0077, 32'h0, 32'h0, 0);
    dmem_ack = 1; #3;
    chk("stray_ack_no_req", {62'd0, dmem_req, stall_m}, 64'd0);
    @(posedge clk); #1;
    issue(1, 0, 1, 5'd10, 32'h0000_0108, 32'h0, 32'h5555_AAAA, 2);
    issue(1, 0, 0, 5'd11, 32'h0000_0ABC, 32'h0, 32'h0, 0);
    RegWriteM = 1; ResultSrcM = 1; RD_M = 5'd12; ALU_ResultM = 32'h300; PCPlus4M = 32'h34;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wait_stall", {62'd0, stall_m, dmem_req}, 64'd3);
    rst = 1'b0; clear_m(); #1;
    chk("midwait_rst_w", {ResultW, PCPlus4W}, 64'd0);
    chk("midwait_rst_w2", {RegWriteW, ResultSrcW, RD_W, ALU_ResultW[24:0], mem_err}, 64'd0);
    chk("midwait_rst_req", {62'd0, dmem_req, stall_m}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle_req", {63'd0, dmem_req}, 64'd0);
    issue(1, 0, 1, 5'd13, 32'h0000_0400, 32'h0, 32'h8765_4321, 2);
    issue(0, 1, 0, 5'd14, 32'h0000_0500, 32'hFFFF_0000, 32'h0, 1);
    idle(3);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RV32 pipeline; directly downstream of the execute stage.
- Consumes the EX/MEM pipeline outputs (RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM) and drives a req/ack data-memory bus.
- Raises stall_m while an access is outstanding. Owns the MEM/WB pipeline register and the writeback result mux that produces ResultW for the register file and forwarding.

Parameters:
- DATA_W, 32, width of data, address and PC words.
- TIMEOUT_CYCLES, 16, cycles spent in WAIT before abort; used only when DMEM_TIMEOUT_EN is defined; minimum 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- RegWriteM  input  1  register write enable from EX/MEM.
- MemWriteM  input  1  store request from EX/MEM.
- ResultSrcM  input  1  1 = load (result from memory), 0 = ALU result.
- RD_M  input  5  destination register.
- PCPlus4M  input  DATA_W  PC+4 of the instruction.
- WriteDataM  input  DATA_W  store data.
- ALU_ResultM  input  DATA_W  ALU result / memory address.
- dmem_req  output  1  bus request.
- dmem_we  output  1  1 = write, 0 = read.
- dmem_addr  output  DATA_W  bus address.
- dmem_wdata  output  DATA_W  bus write data.
- dmem_rdata  input  DATA_W  bus read data, valid when dmem_ack = 1.
- dmem_ack  input  1  single-cycle completion pulse.
- stall_m  output  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- RegWriteW  output  1  MEM/WB register write enable.
- ResultSrcW  output  1  MEM/WB result select.
- RD_W  output  5  MEM/WB destination register.
- PCPlus4W  output  DATA_W  MEM/WB PC+4.
- ALU_ResultW  output  DATA_W  MEM/WB ALU result.
- ReadDataW  output  DATA_W  MEM/WB load data.
- ResultW  output  DATA_W  ResultSrcW ? ReadDataW : ALU_ResultW, combinational.
- mem_err  output  1  sticky timeout flag.

Behaviour:
- mem_op = MemWriteM | ResultSrcM.
- dmem_addr = ALU_ResultM, dmem_wdata = WriteDataM, dmem_we = MemWriteM. All combinational; they stay stable because upstream is frozen by stall_m.
- FSM states IDLE, WAIT; both reset to IDLE.
  - IDLE: dmem_req = mem_op. If mem_op & ~dmem_ack, go to WAIT. If mem_op & dmem_ack (zero-wait access), stay in IDLE.
  - WAIT: dmem_req = 1; go to IDLE on dmem_ack.
  - A dmem_ack with no request outstanding is ignored and does not change state.
- stall_m = mem_op & ~dmem_ack, in either state.
- MEM/WB register updates every rising edge:
  - if stall_m: insert a bubble. RegWriteW = 0, ResultSrcW = 0, RD_W = 0; data fields hold.
  - else: capture the *M inputs. ReadDataW <= dmem_rdata for loads, 0 otherwise.
- Latency: a non-memory instruction reaches the W outputs 1 cycle after entering M. A memory instruction reaches them 1 cycle after its ack cycle.
- Reset (any time, including mid-WAIT):
  - all W outputs 0, mem_err 0, FSM IDLE.
  - dmem_req then follows mem_op combinationally, so it drops with the reset EX/MEM contents.
- A store must not produce RegWriteW = 1 unless RegWriteM = 1.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - when it reaches TIMEOUT_CYCLES-1 without ack: go to IDLE, deassert stall_m for that cycle, and complete the instruction with ReadDataW = 0 and RegWriteW = 0.
  - mem_err is set and stays set until reset.
  - dmem_req is low on the abort cycle; a late ack is ignored.
- Not defined: WAIT persists indefinitely, no counter, mem_err tied 0.

Test Plan:
- ALU op: RegWriteM=1, ResultSrcM=0, RD_M=5, ALU_ResultM=0x0000_0010 -> next cycle RegWriteW=1, RD_W=5, ResultW=0x10; dmem_req never high; stall_m=0.
- Zero-wait load: ResultSrcM=1, addr 0x100, ack same cycle, rdata 0xCAFE_F00D -> stall_m=0, next cycle ReadDataW=0xCAFE_F00D, ResultW=0xCAFE_F00D.
- 3-cycle store: MemWriteM=1, addr 0x200, wdata 0x1234_5678, ack in 3rd cycle -> dmem_req/dmem_we high for 3 cycles, stall_m high for 2, two bubbles (RegWriteW=0), then state IDLE.
- Back-to-back: load with 1 wait state followed by an ALU op -> the load's W outputs appear one cycle before the ALU op's; no instruction is lost or duplicated.
- Reset mid-WAIT: assert rst low during the 2nd wait cycle -> all W outputs 0, mem_err=0; after release a new load completes normally.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=16: load that is never acked -> stall_m high for 15 cycles, then released; RegWriteW=0, mem_err=1 and held; a later ack is ignored.
